// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state and ALU-op encodings for the multi-cycle controller.
// Also holds the opcode-class decode used by the FSM.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_LD     = 4'd0;
  localparam logic [3:0] OP_ST     = 4'd1;
  localparam logic [3:0] OP_ALU_LO = 4'd2;
  localparam logic [3:0] OP_ALU_HI = 4'd10;
  localparam logic [3:0] OP_BEQ    = 4'd11;
  localparam logic [3:0] OP_BNE    = 4'd12;
  localparam logic [3:0] OP_JMP    = 4'd13;

  localparam logic [1:0] ALU_OP_RTYPE  = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_ADDR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_LD, C_ST, C_ALU, C_BEQ, C_BNE, C_JMP, C_ILL
  } op_class_e;

  function automatic op_class_e op_class(
    input logic [3:0] op
  );
    op_class_e c;
    c = C_ILL;
    unique case (1'b1)
      (op == OP_LD):  c = C_LD;
      (op == OP_ST):  c = C_ST;
      (op >= OP_ALU_LO &&
       op <= OP_ALU_HI): c = C_ALU;
      (op == OP_BEQ): c = C_BEQ;
      (op == OP_BNE): c = C_BNE;
      (op == OP_JMP): c = C_JMP;
      default:        c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle: opcode/mem handshake in, strobes out.
// Optional illegal_op line exists only with ILLEGAL_OP_TRAP_EN.
interface multicycle_ctrl_fsm_if #(
  parameter int RETIRE_W = 16
) ();

  logic [3:0]          opcode;
  logic                mem_ready;
  logic                ir_write;
  logic                pc_write;
  logic                jump;
  logic                beq;
  logic                bne;
  logic                mem_read;
  logic                mem_write;
  logic                alu_src;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic [1:0]          alu_op;
  logic [2:0]          state;
  logic                busy;
  logic                halted;
  logic                mem_timeout;
  logic [RETIRE_W-1:0] retired;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                illegal_op;

  modport master (
    input  opcode, mem_ready,
    output ir_write, pc_write, jump,
    output beq, bne, mem_read,
    output mem_write, alu_src,
    output reg_dst, mem_to_reg,
    output reg_write, alu_op, state,
    output busy, halted, mem_timeout,
    output retired, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  ir_write, pc_write, jump,
    input  beq, bne, mem_read,
    input  mem_write, alu_src,
    input  reg_dst, mem_to_reg,
    input  reg_write, alu_op, state,
    input  busy, halted, mem_timeout,
    input  retired, illegal_op
  );
`else
  modport master (
    input  opcode, mem_ready,
    output ir_write, pc_write, jump,
    output beq, bne, mem_read,
    output mem_write, alu_src,
    output reg_dst, mem_to_reg,
    output reg_write, alu_op, state,
    output busy, halted, mem_timeout,
    output retired
  );

  modport slave (
    output opcode, mem_ready,
    input  ir_write, pc_write, jump,
    input  beq, bne, mem_read,
    input  mem_write, alu_src,
    input  reg_dst, mem_to_reg,
    input  reg_write, alu_op, state,
    input  busy, halted, mem_timeout,
    input  retired
  );
`endif

endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// MEM-state wait counter: loads 1 on MEM entry, counts each MEM cycle,
// flags when the current MEM cycle is number MAX.
module mem_wait_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  assign expired = (cnt_q == 8'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = 8'd1;
    else if (en && !expired)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with MEM timeout.
// Build option ILLEGAL_OP_TRAP_EN: opcodes 1110/1111 halt instead of NOP.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int RETIRE_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  multicycle_ctrl_fsm_if.master dp
);

  state_e              state_q, state_d;
  logic [3:0]          opcode_q, opcode_d;
  logic                mem_to_q, mem_to_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  op_class_e           cls;
  state_e              exit_st;
  logic                tmr_load, tmr_exp;
  logic                ir_write, pc_write;
  logic                jump, beq, bne;
  logic                mem_read, mem_write;
  logic                alu_src, reg_dst;
  logic                mem_to_reg, reg_write;
  logic [1:0]          alu_op;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                ill_q, ill_d;
`endif

  assign cls      = op_class(opcode_q);
  assign exit_st  = run ? S_FETCH : S_IDLE;
  assign tmr_load = (state_q != S_MEM) &&
                    (state_d == S_MEM);

  mem_wait_timer #(
    .MAX (MEM_WAIT_MAX)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .en      (state_q == S_MEM),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    mem_to_d   = mem_to_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = ALU_OP_RTYPE;
`ifdef ILLEGAL_OP_TRAP_EN
    ill_d      = ill_q;
`endif
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        opcode_d = dp.opcode;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        unique case (cls)
          C_LD, C_ST: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_ADDR;
            state_d = S_MEM;
          end
          C_ALU: state_d = S_WB;
          C_BEQ: begin
            beq      = 1'b1;
            alu_op   = ALU_OP_BRANCH;
            pc_write = 1'b1;
            state_d  = exit_st;
          end
          C_BNE: begin
            bne      = 1'b1;
            alu_op   = ALU_OP_BRANCH;
            pc_write = 1'b1;
            state_d  = exit_st;
          end
          C_JMP: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            state_d  = exit_st;
          end
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            ill_d    = 1'b1;
            state_d  = S_HALT;
`else
            pc_write = 1'b1;
            state_d  = exit_st;
`endif
          end
        endcase
      end
      S_MEM: begin
        alu_src   = 1'b1;
        alu_op    = ALU_OP_ADDR;
        mem_read  = (cls == C_LD);
        mem_write = (cls == C_ST);
        // ready on the limit cycle still wins
        if (dp.mem_ready) begin
          if (cls == C_ST) begin
            pc_write = 1'b1;
            state_d  = exit_st;
          end else begin
            state_d  = S_WB;
          end
        end else if (tmr_exp) begin
          mem_to_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (cls == C_LD);
        reg_dst    = (cls == C_ALU);
        state_d    = exit_st;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    retired_d = retired_q + RETIRE_W'(pc_write);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      mem_to_q  <= 1'b0;
      retired_q <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      ill_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      mem_to_q  <= mem_to_d;
      retired_q <= retired_d;
`ifdef ILLEGAL_OP_TRAP_EN
      ill_q     <= ill_d;
`endif
    end
  end

  assign dp.ir_write    = ir_write;
  assign dp.pc_write    = pc_write;
  assign dp.jump        = jump;
  assign dp.beq         = beq;
  assign dp.bne         = bne;
  assign dp.mem_read    = mem_read;
  assign dp.mem_write   = mem_write;
  assign dp.alu_src     = alu_src;
  assign dp.reg_dst     = reg_dst;
  assign dp.mem_to_reg  = mem_to_reg;
  assign dp.reg_write   = reg_write;
  assign dp.alu_op      = alu_op;
  assign dp.state       = state_q;
  assign dp.busy        = (state_q != S_IDLE) &&
                          (state_q != S_HALT);
  assign dp.halted      = (state_q == S_HALT);
  assign dp.mem_timeout = mem_to_q;
  assign dp.retired     = retired_q;
`ifdef ILLEGAL_OP_TRAP_EN
  assign dp.illegal_op  = ill_q;
`endif

endmodule
